mult_final_stage_ctrl: RTL and testbench

- Sequencer for the multiplier's final-result stage: the IEEE capture register, the underflow/overflow constant mux, the exception/normal mux and the final result register.
- Accepts one rounded result per transaction from the multiplier core, together with its overflow/underflow flags.
- Drives the stage's load_a, load_b, selector_a and selector_b in a fixed 4-state sequence.
- Presents F_ieee_result as valid with a ready/valid/ack handshake.
- Keeps saturating per-exception event counters for debug and status readout.

---
 rtl/mult_ctrl_pkg.sv | 26 ++
 rtl/mult_final_stage_ctrl_if.sv | 32 +++
 rtl/sat_counter.sv | 28 ++
 rtl/mult_final_stage_ctrl.sv | 80 ++++++++
 tb/tb_mult_final_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared encodings for the multiplier final-stage sequencer: FSM states,
// datapath mux selector values and priority-resolved exception codes.
package mult_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic SEL_A_UNDERFLOW = 1'b0;
  localparam logic SEL_A_OVERFLOW  = 1'b1;
  localparam logic SEL_B_EXCEPTION = 1'b0;
  localparam logic SEL_B_NORMAL    = 1'b1;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_UNF  = 2'b01;
  localparam logic [1:0] EXC_OVF  = 2'b10;

  // Overflow wins when the core flags both: the result saturates to infinity.
  function automatic logic [1:0] resolve_exc(input logic ovf, input logic unf);
    if (ovf) return EXC_OVF;
    else if (unf) return EXC_UNF;
    else return EXC_NONE;
  endfunction

endpackage

// File: rtl/mult_final_stage_ctrl_if.sv
// Handshake, datapath-strobe and status bundle between the multiplier core,
// the final-stage controller and its downstream consumer.
interface mult_final_stage_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             overflow_flag;
  logic             underflow_flag;
  logic             ack;
  logic             clr_cnt;
  logic             ready;
  logic             load_a;
  logic             selector_a;
  logic             selector_b;
  logic             load_b;
  logic             result_valid;
  logic [1:0]       exc_code;
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] unf_cnt;

  modport master (
    output start, overflow_flag, underflow_flag, ack, clr_cnt,
    input  ready, load_a, selector_a, selector_b, load_b, result_valid,
           exc_code, ovf_cnt, unf_cnt
  );

  modport slave (
    input  start, overflow_flag, underflow_flag, ack, clr_cnt,
    output ready, load_a, selector_a, selector_b, load_b, result_valid,
           exc_code, ovf_cnt, unf_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// One-cycle update; synchronous clear takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] value_o
);
  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) value_d = '0;
    else if (inc_i && (value_q != MAX_VAL)) value_d = value_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else value_q <= value_d;
  end

  assign value_o = value_q;
endmodule

// File: rtl/mult_final_stage_ctrl.sv
// Final-stage sequencer: capture (Mealy load_a), select, commit (load_b), hold until ack.
// 4 cycles minimum per result; start is refused (ready=0) outside IDLE, result held while ack=0.
module mult_final_stage_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  mult_final_stage_ctrl_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [1:0] exc_q, exc_d;
  logic       sel_a_q, sel_a_d;
  logic       sel_b_q, sel_b_d;
  logic       in_commit;

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          exc_d   = resolve_exc(bus.overflow_flag, bus.underflow_flag);
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        sel_a_d = exc_q[1] ? SEL_A_OVERFLOW : SEL_A_UNDERFLOW;
        sel_b_d = (exc_q == EXC_NONE) ? SEL_B_NORMAL : SEL_B_EXCEPTION;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_HOLD;
      ST_HOLD:   if (bus.ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      exc_q   <= EXC_NONE;
      sel_a_q <= SEL_A_UNDERFLOW;
      sel_b_q <= SEL_B_NORMAL;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign in_commit        = (state_q == ST_COMMIT);
  assign bus.ready        = (state_q == ST_IDLE);
  // Gated by rst so a start seen during reset never strobes the capture register.
  assign bus.load_a       = rst & bus.ready & bus.start;
  assign bus.load_b       = in_commit;
  assign bus.result_valid = (state_q == ST_HOLD);
  assign bus.selector_a   = sel_a_q;
  assign bus.selector_b   = sel_b_q;
  assign bus.exc_code     = exc_q;

  sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (in_commit & exc_q[1]),
    .clr_i   (bus.clr_cnt),
    .value_o (bus.ovf_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_unf_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (in_commit & ~exc_q[1] & exc_q[0]),
    .clr_i   (bus.clr_cnt),
    .value_o (bus.unf_cnt)
  );
endmodule

// File: tb/tb_mult_final_stage_ctrl.sv
// Bench for mult_final_stage_ctrl: directed scenarios plus a randomized run
// checked against a transaction-timeline reference model.
module tb_mult_final_stage_ctrl;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_ovf = 0;
  int   exp_unf = 0;

  mult_final_stage_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mult_final_stage_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Per-cycle observations of the last transaction driven by txn().
  logic             ob_rdy[16], ob_la[16], ob_lb[16], ob_rv[16], ob_sa[16], ob_sb[16];
  logic [1:0]       ob_exc[16];
  logic [CNT_W-1:0] ob_ovf[16], ob_unf[16];

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic s, input logic o, input logic u, input logic a, input logic c);
    @(negedge clk);
    bus.start = s; bus.overflow_flag = o; bus.underflow_flag = u;
    bus.ack = a; bus.clr_cnt = c;
    #1;
  endtask

  task automatic grab(input int k);
    ob_rdy[k] = bus.ready;      ob_la[k] = bus.load_a;     ob_lb[k] = bus.load_b;
    ob_rv[k]  = bus.result_valid; ob_sa[k] = bus.selector_a; ob_sb[k] = bus.selector_b;
    ob_exc[k] = bus.exc_code;   ob_ovf[k] = bus.ovf_cnt;   ob_unf[k] = bus.unf_cnt;
  endtask

  // Cycle 0 accept, 1 select, 2 commit, 3..3+wait_n hold (ack on the last), then one idle cycle.
  task automatic txn(input logic o, input logic u, input int wait_n, input logic pulse_hold,
                     input logic clr_commit);
    drive(1'b1, o, u, 1'b1, 1'b0);            grab(0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);      grab(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, clr_commit); grab(2);
    for (int i = 0; i < wait_n; i++) begin
      drive(pulse_hold, 1'b1, 1'b1, 1'b0, 1'b0); grab(3 + i);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);      grab(3 + wait_n);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);      grab(4 + wait_n);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    exp_ovf = 0; exp_unf = 0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.overflow_flag = 1'b1; bus.underflow_flag = 1'b0;
    bus.ack = 1'b0; bus.clr_cnt = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({bus.ready, bus.load_a, bus.load_b, bus.result_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_handshake got rdy/la/lb/rv=%b required 1000",
               {bus.ready, bus.load_a, bus.load_b, bus.result_valid});
    end
    n_tests++;
    if ({bus.selector_a, bus.selector_b, bus.exc_code} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_select got sa/sb/exc=%b required 0100",
               {bus.selector_a, bus.selector_b, bus.exc_code});
    end
    n_tests++;
    if ({bus.ovf_cnt, bus.unf_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters got ovf=%0d unf=%0d required 0 0", bus.ovf_cnt, bus.unf_cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_normal();
    logic [4:0] e_la, e_lb, e_rv, e_rdy;
    e_la = 5'b00001; e_lb = 5'b00100; e_rv = 5'b01000; e_rdy = 5'b10001;
    txn(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({ob_la[k], ob_lb[k], ob_rv[k], ob_rdy[k]} !== {e_la[k], e_lb[k], e_rv[k], e_rdy[k]}) begin
        n_fail++;
        $display("FAIL normal_timeline cyc %0d got la/lb/rv/rdy=%b required %b", k,
                 {ob_la[k], ob_lb[k], ob_rv[k], ob_rdy[k]}, {e_la[k], e_lb[k], e_rv[k], e_rdy[k]});
      end
    end
    n_tests++;
    if ({ob_sb[2], ob_exc[1]} !== 3'b100) begin
      n_fail++;
      $display("FAIL normal_select got sb=%b exc=%b required sb=1 exc=00", ob_sb[2], ob_exc[1]);
    end
    n_tests++;
    if (ob_ovf[4] !== CNT_W'(exp_ovf) || ob_unf[4] !== CNT_W'(exp_unf)) begin
      n_fail++;
      $display("FAIL normal_counters got ovf=%0d unf=%0d required %0d %0d",
               ob_ovf[4], ob_unf[4], exp_ovf, exp_unf);
    end
  endtask

  // Shared by the overflow-only and both-flags scenarios: outcome must be identical.
  task automatic test_overflow(input logic also_unf);
    txn(1'b1, also_unf, 0, 1'b0, 1'b0);
    exp_ovf = sat_inc(exp_ovf);
    n_tests++;
    if ({ob_sa[2], ob_sb[2], ob_exc[1]} !== 4'b1010) begin
      n_fail++;
      $display("FAIL ovf_select unf=%b got sa/sb/exc=%b required 1010", also_unf,
               {ob_sa[2], ob_sb[2], ob_exc[1]});
    end
    n_tests++;
    if (ob_ovf[3] !== CNT_W'(exp_ovf) || ob_unf[3] !== CNT_W'(exp_unf)) begin
      n_fail++;
      $display("FAIL ovf_counters unf=%b got ovf=%0d unf=%0d required %0d %0d", also_unf,
               ob_ovf[3], ob_unf[3], exp_ovf, exp_unf);
    end
    n_tests++;
    if ({ob_sa[4], ob_sb[4]} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovf_sel_persist got sa/sb=%b required 10", {ob_sa[4], ob_sb[4]});
    end
  endtask

  task automatic test_backpressure();
    txn(1'b0, 1'b0, 5, 1'b1, 1'b0);
    for (int k = 3; k <= 8; k++) begin
      n_tests++;
      if ({ob_rv[k], ob_la[k], ob_rdy[k], ob_exc[k]} !== 5'b10000) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got rv/la/rdy/exc=%b required 10000", k,
                 {ob_rv[k], ob_la[k], ob_rdy[k], ob_exc[k]});
      end
    end
    n_tests++;
    if ({ob_rdy[9], ob_rv[9]} !== 2'b10 || ob_ovf[9] !== CNT_W'(exp_ovf)) begin
      n_fail++;
      $display("FAIL bp_release got rdy/rv=%b ovf=%0d required 10 ovf=%0d",
               {ob_rdy[9], ob_rv[9]}, ob_ovf[9], exp_ovf);
    end
    txn(1'b0, 1'b1, 0, 1'b0, 1'b0);
    exp_unf = sat_inc(exp_unf);
    n_tests++;
    if (ob_la[0] !== 1'b1 || ob_exc[1] !== 2'b01 || ob_unf[3] !== CNT_W'(exp_unf)) begin
      n_fail++;
      $display("FAIL bp_next_start got la=%b exc=%b unf=%0d required 1 01 %0d",
               ob_la[0], ob_exc[1], ob_unf[3], exp_unf);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, 1'b1, 0, 1'b0, 1'b0);
      exp_unf = sat_inc(exp_unf);
      n_tests++;
      if (ob_unf[3] !== CNT_W'(exp_unf) || ob_ovf[3] !== '0) begin
        n_fail++;
        $display("FAIL sat_unf txn %0d got unf=%0d ovf=%0d required %0d 0",
                 i, ob_unf[3], ob_ovf[3], exp_unf);
      end
    end
    txn(1'b0, 1'b1, 0, 1'b0, 1'b1);
    exp_unf = 0;
    n_tests++;
    if (ob_lb[2] !== 1'b1 || ob_unf[3] !== '0 || ob_unf[4] !== '0) begin
      n_fail++;
      $display("FAIL sat_clear got lb=%b unf=%0d/%0d required 1 0/0", ob_lb[2], ob_unf[3], ob_unf[4]);
    end
  endtask

  task automatic test_async_reset();
    logic seen_lb;
    txn(1'b1, 1'b0, 0, 1'b0, 1'b0);
    exp_ovf = sat_inc(exp_ovf);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({bus.load_b, bus.selector_a, bus.selector_b} !== 3'b110 || bus.ovf_cnt !== CNT_W'(exp_ovf)) begin
      n_fail++;
      $display("FAIL arst_pre got lb/sa/sb=%b ovf=%0d required 110 ovf=%0d",
               {bus.load_b, bus.selector_a, bus.selector_b}, bus.ovf_cnt, exp_ovf);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.ready, bus.load_b, bus.result_valid, bus.selector_a, bus.selector_b, bus.exc_code} !== 7'b1000100
        || bus.ovf_cnt !== '0 || bus.unf_cnt !== '0) begin
      n_fail++;
      $display("FAIL arst_now got rdy/lb/rv/sa/sb/exc=%b ovf=%0d unf=%0d required 1000100 0 0",
               {bus.ready, bus.load_b, bus.result_valid, bus.selector_a, bus.selector_b, bus.exc_code},
               bus.ovf_cnt, bus.unf_cnt);
    end
    exp_ovf = 0; exp_unf = 0;
    @(negedge clk); rst = 1'b1;
    seen_lb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      seen_lb = seen_lb | bus.load_b | bus.result_valid;
    end
    n_tests++;
    if (seen_lb !== 1'b0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_after got lb_or_rv_seen=%b rdy=%b required 0 1", seen_lb, bus.ready);
    end
  endtask

  // Reference model: age = cycles since the accepted start (-1 when idle).
  task automatic test_random();
    int         age, m_ovf, m_unf;
    logic [1:0] m_exc;
    logic       m_sa, m_sb, s, o, u, a, c, idle;
    logic [10:0] got, want;
    pulse_reset();
    age = -1; m_ovf = 0; m_unf = 0; m_exc = 2'b00; m_sa = 1'b0; m_sb = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = 1'($urandom_range(0, 1)); o = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1)); c = ($urandom_range(0, 15) == 0);
      drive(s, o, u, a, c);
      idle = (age < 0);
      want = {idle, idle & s, age == 2, age >= 3, m_sa, m_sb, m_exc, 3'b000};
      got  = {bus.ready, bus.load_a, bus.load_b, bus.result_valid, bus.selector_a,
              bus.selector_b, bus.exc_code, 3'b000};
      n_tests++;
      if (got !== want || bus.ovf_cnt !== CNT_W'(m_ovf) || bus.unf_cnt !== CNT_W'(m_unf)) begin
        n_fail++;
        $display("FAIL random cyc %0d got outs=%b ovf=%0d unf=%0d required outs=%b ovf=%0d unf=%0d",
                 cyc, got, bus.ovf_cnt, bus.unf_cnt, want, m_ovf, m_unf);
      end
      if (age == 2 && !c) begin
        if (m_exc == 2'b10) m_ovf = sat_inc(m_ovf);
        else if (m_exc == 2'b01) m_unf = sat_inc(m_unf);
      end
      if (c) begin m_ovf = 0; m_unf = 0; end
      if (idle) begin
        if (s) begin m_exc = o ? 2'b10 : (u ? 2'b01 : 2'b00); age = 0; end
      end else if (age == 1) begin
        m_sa = (m_exc == 2'b10); m_sb = (m_exc == 2'b00);
      end else if (age >= 3 && a) begin
        age = -2;
      end
      if (age != -1) age = (age == -2) ? -1 : age + 1;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_backpressure();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
